// File: rtl/music_pkg.sv
// Shared definitions for the note-ROM song player: state encoding, scale
// constants and the base-octave half-period table at 100 MHz.
package music_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_DIV,
    S_PLAY
  } state_t;

  localparam int NOTES_PER_OCT = 12;
  localparam int MAX_OCT       = 6;

  // Half-periods in clk cycles for note 1 (A1) through note 12 (G#2).
  localparam int unsigned BASE_HP [NOTES_PER_OCT] = '{
    909091, 858068, 809917, 764460, 721543, 681049,
    642824, 606745, 572688, 540546, 510210, 481575
  };

  function automatic int unsigned base_hp(input logic [3:0] idx);
    return (idx < 4'(NOTES_PER_OCT)) ? BASE_HP[idx] : 0;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: a half-period down-counter that toggles the speaker
// each time it reaches zero. restart silences and re-phases the tone.
module tone_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            restart,
  input  logic [HP_W-1:0] half_period,
  output logic            speaker
);

  logic [HP_W-1:0] cnt;
  logic            armed;

  // The first enabled cycle only loads the counter, so the first edge comes a
  // full half-period after the note starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments make every flop see pre-edge values; blocking ones here would race.
      cnt     <= '0;
      armed   <= 1'b0;
      speaker <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      armed   <= 1'b0;
      speaker <= 1'b0;
    end else if (en) begin
      if (!armed) begin
        cnt   <= half_period - HP_W'(1);
        armed <= 1'b1;
      end else if (cnt == '0) begin
        cnt     <= half_period - HP_W'(1);
        speaker <= ~speaker;
      end else begin
        cnt <= cnt - HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/song_player.sv
// Plays a song from the note ROM: one ROM entry per beat, note index turned
// into octave/semitone by repeated subtraction, then sounded by tone_gen.
module song_player
  import music_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int HP_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [7:0] song_last,
  output logic [7:0] address,
  input  logic [7:0] note,
  output logic       speaker,
  output logic       playing,
  output logic [7:0] cur_note,
  output logic       done
);

  localparam int BEAT_W = $clog2(TICKS_PER_BEAT);

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [7:0]        n;
  logic [7:0]        rem;
  logic [2:0]        oct;
  logic              rest;
  logic              beat_end;
  logic              tone_en;
  logic              tone_restart;
  logic [HP_W-1:0]   half_period;

  // DIV is at most seven cycles, so with >= 16 ticks the beat always ends in PLAY.
  assign beat_end     = (state == S_PLAY) && (beat_cnt == BEAT_W'(TICKS_PER_BEAT - 1));
  assign half_period  = HP_W'(base_hp(rem[3:0]) >> oct);
  assign tone_en      = (state == S_PLAY) && !rest;
  assign tone_restart = stop || beat_end || (state != S_PLAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      address  <= '0;
      beat_cnt <= '0;
      n        <= '0;
      rem      <= '0;
      oct      <= '0;
      rest     <= 1'b0;
      playing  <= 1'b0;
      cur_note <= '0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= S_IDLE;
      address  <= '0;
      beat_cnt <= '0;
      playing  <= 1'b0;
      cur_note <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) beat_cnt <= beat_cnt + BEAT_W'(1);
      case (state)
        S_IDLE: begin
          address <= '0;
          if (start) begin
            state    <= S_FETCH;
            beat_cnt <= '0;
            playing  <= 1'b1;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          n    <= note;
          rem  <= note - 8'd1;
          oct  <= '0;
          rest <= (note == 8'd0);
          state <= (note == 8'd0) ? S_PLAY : S_DIV;
        end
        S_DIV: begin
          if (rem >= 8'(NOTES_PER_OCT)) begin
            rem <= rem - 8'(NOTES_PER_OCT);
            oct <= oct + 3'd1;
            // Above the top octave the note is treated as silence.
            if (oct == 3'(MAX_OCT - 1)) begin
              rest  <= 1'b1;
              state <= S_PLAY;
            end
          end else begin
            state    <= S_PLAY;
            cur_note <= n;
          end
        end
        S_PLAY: begin
          if (beat_end) begin
            cur_note <= '0;
            beat_cnt <= '0;
            if (address != song_last) begin
              address <= address + 8'd1;
              state   <= S_FETCH;
            end else if (loop_en) begin
              address <= '0;
              state   <= S_FETCH;
            end else begin
              address <= '0;
              state   <= S_IDLE;
              playing <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (tone_en),
    .restart    (tone_restart),
    .half_period(half_period),
    .speaker    (speaker)
  );

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player: random songs against a beat-level
// reference model, plus a long-beat instance that measures real tone periods.
module tb_song_player;

  localparam int TPB  = 64;
  localparam int TPB2 = 50000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [7:0] song_last = '0;
  logic [7:0] address, note, cur_note;
  logic       speaker, playing, done;

  logic       start2 = 1'b0;
  logic [7:0] address2, note2, cur_note2;
  logic       speaker2, playing2, done2;

  int rom [256];
  int rom2;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned ref_base [12] = '{909091, 858068, 809917, 764460, 721543, 681049,
                                 642824, 606745, 572688, 540546, 510210, 481575};

  always #5 clk = ~clk;

  // Note ROMs with one clock of read latency.
  always @(posedge clk) note  <= 8'(rom[address]);
  always @(posedge clk) note2 <= (address2 == 8'd0) ? 8'(rom2) : 8'd0;

  song_player #(.TICKS_PER_BEAT(TPB), .HP_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .song_last(song_last), .address(address), .note(note), .speaker(speaker),
    .playing(playing), .cur_note(cur_note), .done(done)
  );

  song_player #(.TICKS_PER_BEAT(TPB2), .HP_W(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0), .loop_en(1'b0),
    .song_last(8'd0), .address(address2), .note(note2), .speaker(speaker2),
    .playing(playing2), .cur_note(cur_note2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ref_rest(input int n);
    return (n == 0) || (n > 72);
  endfunction

  function automatic int ref_hp(input int n);
    return int'(ref_base[(n - 1) % 12] >> ((n - 1) / 12));
  endfunction

  // Beat cycle at which the note starts sounding: fetch, capture, then one
  // cycle per subtraction plus the final "remainder < 12" cycle.
  function automatic int ref_play_start(input int n);
    if (n == 0) return 2;
    if ((n - 1) / 12 >= 6) return 8;
    return 3 + (n - 1) / 12;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " playing"}, playing, 0);
    check({tag, " address"}, address, 0);
    check({tag, " speaker"}, speaker, 0);
    check({tag, " cur_note"}, cur_note, 0);
  endtask

  // Called at a negedge with the player idle. ending: 0 = natural end,
  // 1 = stop asserted on the final beat-expiry cycle.
  task automatic play_song(input int last, input bit lp, input int nbeats, input int ending);
    song_last = 8'(last);
    loop_en   = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      int a, n, ec, p, pj, bad_addr, bad_cur, bad_ctl, bad_spk;
      bit rst_note;
      a  = lp ? b % (last + 1) : b;
      n  = rom[a];
      rst_note = ref_rest(n);
      ec = rst_note ? 0 : n;
      p  = ref_play_start(n);
      pj = $urandom_range(5, 50);
      bad_addr = 0; bad_cur = 0; bad_ctl = 0; bad_spk = 0;
      if (b > 0) @(negedge clk);
      for (int j = 0; j < TPB; j++) begin
        if (j > 0) @(negedge clk);
        if (address !== 8'(a)) bad_addr++;
        if (cur_note !== 8'((j >= p) ? ec : 0)) bad_cur++;
        if (playing !== 1'b1 || done !== 1'b0) bad_ctl++;
        if ((rst_note || j < 2) && speaker !== 1'b0) bad_spk++;
        start = (j == pj);
      end
      check($sformatf("beat%0d addr", b), bad_addr, 0);
      check($sformatf("beat%0d cur_note n=%0d", b, n), bad_cur, 0);
      check($sformatf("beat%0d playing/done", b), bad_ctl, 0);
      check($sformatf("beat%0d speaker silent", b), bad_spk, 0);
      if (!rst_note) check($sformatf("beat%0d half_period n=%0d", b, n), dut.half_period, ref_hp(n));
    end
    if (ending == 1) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop@expiry done", done, 0);
      check_idle("stop@expiry");
      @(negedge clk);
      check("stop@expiry done later", done, 0);
      check("stop@expiry stays idle", playing, 0);
    end else begin
      @(negedge clk);
      check("end done pulse", done, 1);
      check_idle("end");
      @(negedge clk);
      check("end done one cycle", done, 0);
      check("end stays idle", playing, 0);
    end
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 0;
    rom2 = 0;

    // Reset values.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset done", done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("post-reset hold");

    // Directed pitches, rest and out-of-range entries, natural end.
    rom[0] = 49; rom[1] = 1; rom[2] = 34; rom[3] = 0;
    rom[4] = 80; rom[5] = 72; rom[6] = 73;
    play_song(6, 1'b0, 7, 0);

    // Stop on the expiry cycle of the last entry, no loop.
    rom[0] = 12; rom[1] = 0; rom[2] = 60; rom[3] = 25;
    play_song(3, 1'b0, 4, 1);

    // Looping: 0,1,2,3,0,1,... with no done, stopped on an expiry.
    play_song(3, 1'b1, 10, 1);

    // Random songs.
    for (int s = 0; s < 4; s++) begin
      int last;
      last = $urandom_range(1, 5);
      for (int i = 0; i <= last; i++)
        rom[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 90);
      play_song(last, 1'(s % 2), last + 1 + (s % 2) * 3, s % 2);
    end

    // start and stop together while idle.
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_idle("start+stop");
    @(negedge clk);
    check_idle("start+stop after");

    // Stop mid-beat.
    song_last = 8'd3; loop_en = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid-beat playing before stop", playing, 1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check_idle("stop mid-beat");
    check("stop mid-beat done", done, 0);

    // Asynchronous reset in the middle of the second beat.
    rom[1] = 13;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (TPB + 30) @(negedge clk);
    check("pre-reset address", address, 1);
    #1 rst_n = 1'b0;
    #1;
    check_idle("async reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("after reset release");
    check("after reset done", done, 0);

    // Real tone period on a long-beat instance.
    begin
      int hp, t1, t2, k;
      bit prev, got_done, rising;
      rom2 = $urandom_range(64, 72);
      hp   = ref_hp(rom2);
      t1 = -1; t2 = -1; got_done = 0; rising = 0;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      prev = speaker2;
      k = 0;
      while (k < TPB2 + 20 && !got_done) begin
        @(negedge clk);
        k++;
        if (speaker2 !== prev) begin
          if (t1 < 0) begin
            t1 = k;
            rising = (speaker2 === 1'b1);
          end else if (t2 < 0) begin
            t2 = k;
          end
        end
        prev = speaker2;
        if (done2 === 1'b1) got_done = 1;
      end
      check("tone first edge rising", rising, 1);
      check($sformatf("tone half-period n=%0d", rom2), t2 - t1, hp);
      check("tone done seen", got_done, 1);
      check("tone speaker idle", speaker2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Reader/consumer side of the note ROM interface.
- Drives the 8-bit ROM address at a fixed tempo and consumes the 8-bit note index. The ROM returns the note one clock after the address, registered on posedge clk.
- Converts each note index to a square-wave half-period.
- Drives the speaker pin, with start/stop/loop control from board switches.

Parameters:
- TICKS_PER_BEAT, 12_500_000: clk cycles per ROM entry (one eighth-note at 100 MHz). Must be >= 16.
- HP_W, 20: width of the half-period counter.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: level/pulse; begins playback from address 0 when idle.
- stop, input, 1: aborts playback.
- loop_en, input, 1: on the last entry, restart at 0 instead of finishing.
- song_last, input, 8: address of the final ROM entry (195 for song 1, 242 for song 2).
- address, output, 8: ROM address.
- note, input, 8: ROM data, valid the cycle after address is sampled.
- speaker, output, 1: square-wave audio.
- playing, output, 1: high in any non-IDLE state.
- cur_note, output, 8: note currently sounding; 0 when idle or resting.
- done, output, 1: one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low: state=IDLE, address=0, speaker=0, playing=0, cur_note=0, done=0, all counters=0.
- States: IDLE, FETCH, CAPTURE, DIV, PLAY.
- IDLE:
  - address=0.
  - If start=1 and stop=0, go to FETCH and clear beat_cnt.
- FETCH (1 cycle): address stable; the ROM samples it at the end of this cycle. Next state CAPTURE.
- CAPTURE (1 cycle):
  - Register the note input into n.
  - Set rem = n-1 and oct = 0, then go to DIV.
  - If n==0, mark as a rest and go straight to PLAY.
  - Reset the tone counter and set speaker=0.
- DIV (one subtraction per cycle):
  - While rem >= 12: rem -= 12 and oct += 1.
  - When rem < 12, go to PLAY.
  - If oct reaches 6 (n > 72), mark as a rest and go to PLAY. Width: 8-bit rem, 3-bit oct.
- PLAY:
  - half_period = BASE_HP[rem] >> oct.
  - The tone counter loads half_period-1, counts down, and toggles speaker at 0.
  - On a rest, speaker is held at 0 and cur_note=0; otherwise cur_note=n.
- Beat timing:
  - beat_cnt increments every cycle in FETCH/CAPTURE/DIV/PLAY and is cleared on each entry to FETCH.
  - Each ROM entry therefore occupies exactly TICKS_PER_BEAT cycles, fetch overhead included.
- Beat expiry (beat_cnt == TICKS_PER_BEAT-1, which can only occur in PLAY):
  - address != song_last: address += 1, go to FETCH.
  - address == song_last and loop_en=1: address = 0, go to FETCH.
  - address == song_last and loop_en=0: done=1 for one cycle, go to IDLE, address = 0.
- Address wrap: 255 → 0 occurs only through the song_last rule. address never exceeds song_last unless song_last changes mid-song; in that case compare for equality only, and address wraps naturally at 255.
- Repeated identical notes re-enter FETCH/CAPTURE, so tone phase restarts each beat. This is intended: it produces audible articulation.
- stop=1 in any state:
  - Next cycle IDLE, address=0, speaker=0, cur_note=0, no done pulse.
  - stop wins over a simultaneous start or beat expiry.
- start while not IDLE is ignored.
- Reset mid-operation behaves identically to the reset state above.

Decomposition:
- music_pkg holds:
  - The state enum.
  - NOTES_PER_OCT=12.
  - MAX_OCT=6.
  - BASE_HP[0..11], the half-periods at 100 MHz for note 1=A1 through note 12=G#2: 909091, 858068, 809917, 764460, 721543, 681049, 642824, 606745, 572688, 540546, 510210, 481575.
- One sub-module, tone_gen: inputs clk, rst_n, en, restart, half_period[HP_W-1:0]; output speaker. It contains the down-counter and toggle flop.

Test Plan:
- Reset and idle: assert rst_n=0 mid-PLAY → address=0, speaker=0, playing=0 immediately (asynchronous). After release with start=0, outputs hold.
- Fetch latency: TICKS_PER_BEAT=64, ROM model with 1-cycle latency, start pulse → address 0 held 64 cycles, then 1; cur_note equals ROM[k] from the first PLAY cycle of each beat.
- Pitch: ROM entry 49, TICKS_PER_BEAT=400000 → speaker toggles every 56818 cycles (A5). Entry 1 → 909091. Entry 34 → oct=2, rem=9, half-period 135136.
- Rest and out-of-range: entries 0 and 80 → speaker stays 0 and cur_note=0 for the whole beat.
- End of song: song_last=3, loop_en=0 → done pulses once after 4 beats and returns to IDLE. With loop_en=1 → address sequence 0,1,2,3,0,1… and no done.
- Stop precedence: stop and start asserted together in IDLE → stays IDLE. stop asserted on the beat-expiry cycle at song_last → IDLE, done=0.
